// File: rtl/uart_pkg.sv
// Shared UART definitions: line levels, baud-counter helpers and parity.
package uart_pkg;

  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;
  localparam logic LINE_STOP  = 1'b1;

  localparam int unsigned DEFAULT_CLKRATE = 100000000;
  localparam int unsigned DEFAULT_BAUD    = 115200;

  // Clock cycles per bit period.
  function automatic int unsigned baud_counter_max(input int unsigned clkrate,
                                                   input int unsigned baud);
    return clkrate / baud;
  endfunction

  // Cycles from the start edge to the middle of the start bit.
  function automatic int unsigned baud_half(input int unsigned clkrate,
                                            input int unsigned baud);
    return baud_counter_max(clkrate, baud) / 2;
  endfunction

  // Width of a counter that must hold 0 .. max_count-1 (at least one bit).
  function automatic int unsigned counter_width(input int unsigned max_count);
    return (max_count > 1) ? $clog2(max_count) : 1;
  endfunction

  localparam int unsigned BAUD_COUNTER_MAX = baud_counter_max(DEFAULT_CLKRATE, DEFAULT_BAUD);
  localparam int unsigned HALF             = baud_half(DEFAULT_CLKRATE, DEFAULT_BAUD);
  localparam int unsigned BAUD_CNT_W       = counter_width(BAUD_COUNTER_MAX);

  // Even parity bit: 1 when the word has an odd number of ones.
  // Narrower words are zero-extended, which leaves the result unchanged.
  function automatic logic parity(input logic [31:0] bits);
    return ^bits;
  endfunction

endpackage

// File: rtl/uart_sync_edge.sv
// Two-flop synchronizer for an asynchronous input plus a falling-edge detect.
module uart_sync_edge #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic sync_out,
  output logic fall
);

  logic meta;
  logic sync_q;
  logic prev_q;

  // Synchronizer chain and previous-value register for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta   <= RESET_VAL;
      sync_q <= RESET_VAL;
      prev_q <= RESET_VAL;
    end else begin
      meta   <= async_in;
      sync_q <= meta;
      prev_q <= sync_q;
    end
  end

  assign sync_out = sync_q;
  assign fall     = prev_q & ~sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8E1-style frames, mid-bit oversampling, valid/ready output
// with per-word parity/framing status and an overrun pulse on dropped words.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKRATE     = 100000000,
  parameter int unsigned BAUD        = 115200,
  parameter int unsigned WORD_LENGTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   UART_RX,
  output logic [WORD_LENGTH-1:0] rx_data,
  output logic                   rx_data_valid,
  input  logic                   rx_data_ready,
  output logic                   parity_err,
  output logic                   frame_err,
  output logic                   overrun
);

  localparam int unsigned CNT_MAX  = baud_counter_max(CLKRATE, BAUD);
  localparam int unsigned CNT_HALF = baud_half(CLKRATE, BAUD);
  localparam int unsigned CNT_W    = counter_width(CNT_MAX);
  localparam int unsigned BIT_W    = counter_width(WORD_LENGTH);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  rx_state_t state, state_next;

  logic                   line;
  logic                   line_fall;
  logic [CNT_W-1:0]       cnt;
  logic [BIT_W-1:0]       bit_cnt;
  logic [WORD_LENGTH-1:0] shift;
  logic                   par_err_q;
  logic                   tick_half;
  logic                   tick_full;
  logic                   smp_data;
  logic                   smp_parity;
  logic                   smp_stop;

  uart_sync_edge #(
    .RESET_VAL(LINE_IDLE)
  ) u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .async_in(UART_RX),
    .sync_out(line),
    .fall    (line_fall)
  );

  assign tick_half = (cnt == CNT_W'(CNT_HALF - 1));
  assign tick_full = (cnt == CNT_W'(CNT_MAX - 1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (line_fall) state_next = START;
      START:   if (tick_half) state_next = (line == LINE_START) ? DATA : IDLE;
      DATA:    if (tick_full && bit_cnt == BIT_W'(WORD_LENGTH - 1)) state_next = PARITY;
      PARITY:  if (tick_full) state_next = STOP;
      STOP:    if (tick_full) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Sample strobes decoded from state and baud count.
  always_comb begin
    smp_data   = 1'b0;
    smp_parity = 1'b0;
    smp_stop   = 1'b0;
    unique case (state)
      DATA:    smp_data   = tick_full;
      PARITY:  smp_parity = tick_full;
      STOP:    smp_stop   = tick_full;
      default: ;
    endcase
  end

  // Baud counter: clears on any state change and on wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                cnt <= '0;
    else if (state_next != state || tick_full) cnt <= '0;
    else                                       cnt <= cnt + 1'b1;
  end

  // Data shift register, bit counter and parity check.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift     <= '0;
      bit_cnt   <= '0;
      par_err_q <= 1'b0;
    end else begin
      if (state != DATA) bit_cnt <= '0;
      else if (smp_data) bit_cnt <= bit_cnt + 1'b1;
      if (smp_data)   shift     <= {line, shift[WORD_LENGTH-1:1]};
      if (smp_parity) par_err_q <= (line != parity(32'(shift)));
    end
  end

  // Delivery at the stop sample; a pending unaccepted word blocks the new one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data       <= '0;
      rx_data_valid <= 1'b0;
      parity_err    <= 1'b0;
      frame_err     <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (smp_stop && rx_data_valid && !rx_data_ready) begin
        overrun <= 1'b1;
      end else if (smp_stop) begin
        rx_data       <= shift;
        parity_err    <= par_err_q;
        frame_err     <= (line != LINE_STOP);
        rx_data_valid <= 1'b1;
      end else if (rx_data_valid && rx_data_ready) begin
        rx_data_valid <= 1'b0;
      end
    end
  end

endmodule
